// File: rtl/bitslip_pkg.sv
// Shared types and constants for the LVDS frame-alignment controller.
package bitslip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSearch,
        StSlip,
        StSettle,
        StVerify,
        StLocked,
        StFail
    } state_e;

    localparam int unsigned DefWidth         = 8;
    localparam int unsigned DefMatchCount    = 4;
    localparam int unsigned DefSettleCycles  = 4;
    localparam int unsigned DefLossCount     = 8;
    localparam int unsigned DefTimeoutFrames = 1024;
    localparam int unsigned MaxWidth         = 16;

    // Aligned frame word: upper half zeros, lower half ones.
    function automatic logic [MaxWidth-1:0] p0_pattern(input int unsigned width);
        logic [MaxWidth-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width / 2) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/frame_pattern_classify.sv
// Maps a deserialized frame word to (valid, rotation) against rotations of P0.
module frame_pattern_classify
    import bitslip_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH-1:0]         word_i,
    output logic                     valid_o,
    output logic [$clog2(WIDTH)-1:0] rot_o
);

    localparam int unsigned KW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] P0 = WIDTH'(p0_pattern(WIDTH));

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WIDTH - n));
    endfunction

    always_comb begin
        valid_o = 1'b0;
        rot_o   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (word_i == rotl(P0, k)) begin
                valid_o = 1'b1;
                rot_o   = KW'(k);
            end
        end
    end

endmodule

// File: rtl/bitslip_align.sv
// Frame-alignment controller: debounces the frame rotation, issues BITSLIP pulses,
// verifies alignment and tracks loss of lock.
module bitslip_align
    import bitslip_pkg::*;
#(
    parameter int unsigned WIDTH          = DefWidth,
    parameter int unsigned MATCH_COUNT    = DefMatchCount,
    parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
    parameter int unsigned LOSS_COUNT     = DefLossCount,
    parameter int unsigned TIMEOUT_FRAMES = DefTimeoutFrames
) (
    input  logic                     clk_div,
    input  logic                     reset_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic [WIDTH-1:0]         frame_in,
    output logic                     bitslip,
    output logic [$clog2(WIDTH)-1:0] bitslip_count,
    output logic                     locked,
    output logic                     align_err
);

    localparam int unsigned KW = $clog2(WIDTH);
    localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_FRAMES + 1);

    state_e          state_q, state_d;
    logic [WIDTH-1:0] stage1_q, stage1_d, stage2_q, stage2_d;
    logic [MW-1:0]   match_q, match_d;
    logic [KW-1:0]   prev_k_q, prev_k_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic [LW-1:0]   loss_q, loss_d;
    logic [KW-1:0]   remaining_q, remaining_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [KW-1:0]   count_q, count_d;
    logic            bitslip_q, bitslip_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;

    logic            word_valid;
    logic [KW-1:0]   word_rot;
    logic            word_is_p0;

    frame_pattern_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .word_i  (stage2_q),
        .valid_o (word_valid),
        .rot_o   (word_rot)
    );

    assign word_is_p0 = word_valid && (word_rot == '0);

    always_comb begin
        state_d     = state_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        match_d     = match_q;
        prev_k_d    = prev_k_q;
        timeout_d   = timeout_q;
        loss_d      = loss_q;
        remaining_d = remaining_q;
        settle_d    = settle_q;
        count_d     = count_q;
        locked_d    = locked_q;
        err_d       = err_q;
        bitslip_d   = 1'b0;

        if (ena) begin
            stage1_d = frame_in;
            stage2_d = stage1_q;
            if (start) begin
                state_d     = StSearch;
                match_d     = '0;
                prev_k_d    = '0;
                timeout_d   = '0;
                loss_d      = '0;
                remaining_d = '0;
                settle_d    = '0;
                count_d     = '0;
                locked_d    = 1'b0;
                err_d       = 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StSearch: begin
                        timeout_d = timeout_q + 1'b1;
                        if (!word_valid) begin
                            match_d = '0;
                        end else if (match_q != '0 && word_rot == prev_k_q) begin
                            match_d = match_q + 1'b1;
                        end else begin
                            match_d = MW'(1);
                        end
                        prev_k_d = word_rot;
                        if (timeout_d == TW'(TIMEOUT_FRAMES)) begin
                            state_d = StFail;
                            err_d   = 1'b1;
                        end else if (match_d == MW'(MATCH_COUNT)) begin
                            count_d = word_rot;
                            match_d = '0;
                            if (word_rot == '0) begin
                                state_d  = StLocked;
                                locked_d = 1'b1;
                                loss_d   = '0;
                            end else begin
                                state_d     = StSlip;
                                remaining_d = word_rot;
                                bitslip_d   = 1'b1;
                            end
                        end
                    end
                    StSlip: begin
                        // A pulse suppressed by ena is re-issued before leaving SLIP.
                        if (bitslip_q) begin
                            remaining_d = remaining_q - 1'b1;
                            settle_d    = SW'(SETTLE_CYCLES);
                            state_d     = StSettle;
                        end else begin
                            bitslip_d = 1'b1;
                        end
                    end
                    StSettle: begin
                        settle_d = settle_q - 1'b1;
                        if (settle_q == SW'(1)) begin
                            if (remaining_q != '0) begin
                                state_d   = StSlip;
                                bitslip_d = 1'b1;
                            end else begin
                                state_d = StVerify;
                                match_d = '0;
                            end
                        end
                    end
                    StVerify: begin
                        timeout_d = timeout_q + 1'b1;
                        if (timeout_d == TW'(TIMEOUT_FRAMES)) begin
                            state_d = StFail;
                            err_d   = 1'b1;
                        end else if (word_is_p0) begin
                            match_d = match_q + 1'b1;
                            if (match_d == MW'(MATCH_COUNT)) begin
                                state_d  = StLocked;
                                locked_d = 1'b1;
                                loss_d   = '0;
                                match_d  = '0;
                            end
                        end else begin
                            state_d = StSearch;
                            match_d = '0;
                        end
                    end
                    StLocked: begin
                        if (word_is_p0) begin
                            loss_d = '0;
                        end else begin
                            loss_d = loss_q + 1'b1;
                            if (loss_d == LW'(LOSS_COUNT)) begin
                                state_d   = StSearch;
                                locked_d  = 1'b0;
                                timeout_d = '0;
                                match_d   = '0;
                                loss_d    = '0;
                            end
                        end
                    end
                    StFail: ;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_div) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            stage1_q    <= '0;
            stage2_q    <= '0;
            match_q     <= '0;
            prev_k_q    <= '0;
            timeout_q   <= '0;
            loss_q      <= '0;
            remaining_q <= '0;
            settle_q    <= '0;
            count_q     <= '0;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            match_q     <= match_d;
            prev_k_q    <= prev_k_d;
            timeout_q   <= timeout_d;
            loss_q      <= loss_d;
            remaining_q <= remaining_d;
            settle_q    <= settle_d;
            count_q     <= count_d;
            bitslip_q   <= bitslip_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign bitslip       = bitslip_q;
    assign bitslip_count = count_q;
    assign locked        = locked_q;
    assign align_err     = err_q;

endmodule

// File: tb/tb_bitslip_align.sv
// Scoreboard bench for bitslip_align: stimulus queues expected output events, a negedge
// monitor pops and compares them against what the DUTs present.
module tb_bitslip_align;

    localparam int EvSlip     = 0;
    localparam int EvLockRise = 1;
    localparam int EvLockFall = 2;
    localparam int EvErrRise  = 3;
    localparam int EvErrFall  = 4;

    typedef struct {
        int src;
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic        clk_div;
    logic        reset_n, ena, start8, start16;
    logic [7:0]  frame8;
    logic [15:0] frame16;
    logic        bs8, lk8, err8, bs16, lk16, err16;
    logic [2:0]  cnt8;
    logic [3:0]  cnt16;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    logic model8 = 1'b0, model16 = 1'b0;
    int  rot8 = 0, rot16 = 0;
    logic lk8_p = 1'b0, err8_p = 1'b0, lk16_p = 1'b0, err16_p = 1'b0;

    bitslip_align u_dut8 (
        .clk_div       (clk_div),
        .reset_n       (reset_n),
        .ena           (ena),
        .start         (start8),
        .frame_in      (frame8),
        .bitslip       (bs8),
        .bitslip_count (cnt8),
        .locked        (lk8),
        .align_err     (err8)
    );

    bitslip_align #(
        .WIDTH (16)
    ) u_dut16 (
        .clk_div       (clk_div),
        .reset_n       (reset_n),
        .ena           (ena),
        .start         (start16),
        .frame_in      (frame16),
        .bitslip       (bs16),
        .bitslip_count (cnt16),
        .locked        (lk16),
        .align_err     (err16)
    );

    initial begin
        clk_div = 1'b0;
        forever #5 clk_div = ~clk_div;
    end

    always @(posedge clk_div) cyc <= cyc + 1;

    function automatic logic [7:0] pat8(input int k);
        logic [7:0] p;
        p = 8'h0F;
        return (p << k) | (p >> (8 - k));
    endfunction

    function automatic logic [15:0] pat16(input int k);
        logic [15:0] p;
        p = 16'h00FF;
        return (p << k) | (p >> (16 - k));
    endfunction

    task automatic push(input int src, input int kind, input int c, input int val);
        ev_t e;
        e.src  = src;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int src, input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected src=%0d kind=%0d val=%0d at cyc=%0d",
                     src, kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.src != src || e.kind != kind || e.cyc != cyc || e.val != val) begin
                bad++;
                $display("FAIL event: got src=%0d kind=%0d cyc=%0d val=%0d, want src=%0d kind=%0d cyc=%0d val=%0d",
                         src, kind, cyc, val, e.src, e.kind, e.cyc, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every bitslip pulse and every locked/align_err edge is an event.
    always @(negedge clk_div) begin
        if (bs8 === 1'b1) check_ev(0, EvSlip, int'(cnt8));
        if (lk8 !== lk8_p && reset_n) check_ev(0, lk8 ? EvLockRise : EvLockFall, int'(cnt8));
        if (err8 !== err8_p && reset_n) check_ev(0, err8 ? EvErrRise : EvErrFall, int'(cnt8));
        if (bs16 === 1'b1) check_ev(1, EvSlip, int'(cnt16));
        if (lk16 !== lk16_p && reset_n) check_ev(1, lk16 ? EvLockRise : EvLockFall, int'(cnt16));
        if (err16 !== err16_p && reset_n) check_ev(1, err16 ? EvErrRise : EvErrFall, int'(cnt16));
        lk8_p   = lk8;
        err8_p  = err8;
        lk16_p  = lk16;
        err16_p = err16;
    end

    // One cycle; the ISERDES models rotate their word back by one on each qualified pulse.
    task automatic tick();
        @(negedge clk_div);
        if (model8 && bs8 && ena) begin
            rot8   = (rot8 + 7) % 8;
            frame8 = pat8(rot8);
        end
        if (model16 && bs16 && ena) begin
            rot16   = (rot16 + 15) % 16;
            frame16 = pat16(rot16);
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset_n = 1'b0;
        ena     = 1'b1;
        start8  = 1'b0;
        start16 = 1'b0;
        frame8  = '0;
        frame16 = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_bitslip8", int'(bs8), 0);
        chk("rst_count8", int'(cnt8), 0);
        chk("rst_locked8", int'(lk8), 0);
        chk("rst_err8", int'(err8), 0);
        chk("rst_bitslip16", int'(bs16), 0);
        chk("rst_locked16", int'(lk16), 0);

        // Aligned word arriving with start: pipeline fill plus MATCH_COUNT words.
        frame8 = pat8(0);
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvLockRise, s + 5, 0);
        tick();
        start8 = 1'b0;
        run_to(s + 8);
        chk("k0_locked", int'(lk8), 1);
        chk("k0_count", int'(cnt8), 0);

        // Seven bad words then P0: lock must hold.
        for (int i = 0; i < 7; i++) begin
            frame8 = 8'hAA;
            tick();
        end
        frame8 = pat8(0);
        repeat (12) tick();
        chk("loss7_locked", int'(lk8), 1);

        // Eight bad words: drop lock, then re-search on P0.
        s = cyc;
        push(0, EvLockFall, s + 10, 0);
        push(0, EvLockRise, s + 14, 0);
        for (int i = 0; i < 8; i++) begin
            frame8 = 8'hAA;
            tick();
        end
        frame8 = pat8(0);
        run_to(s + 18);
        chk("loss8_relocked", int'(lk8), 1);

        // Rotation 5 (8'b11100001) with ISERDES model: five pulses 5 cycles apart.
        model8 = 1'b1;
        rot8   = 5;
        frame8 = pat8(5);
        repeat (3) tick();
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvLockFall, s, 0);
        for (int j = 0; j < 5; j++) push(0, EvSlip, s + 4 + 5 * j, 5);
        push(0, EvLockRise, s + 33, 5);
        tick();
        start8 = 1'b0;
        run_to(s + 40);
        chk("k5_locked", int'(lk8), 1);
        chk("k5_count", int'(cnt8), 5);

        // Rotation 2 with ena low for 10 cycles in the middle of SETTLE.
        rot8   = 2;
        frame8 = pat8(2);
        repeat (3) tick();
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvLockFall, s, 0);
        push(0, EvSlip, s + 4, 2);
        push(0, EvSlip, s + 19, 2);
        push(0, EvLockRise, s + 28, 2);
        tick();
        start8 = 1'b0;
        run_to(s + 6);
        ena = 1'b0;
        repeat (10) tick();
        chk("freeze_count", int'(cnt8), 2);
        chk("freeze_locked", int'(lk8), 0);
        ena = 1'b1;
        run_to(s + 35);
        chk("k2_locked", int'(lk8), 1);
        chk("k2_count", int'(cnt8), 2);

        // Reset asserted while the SLIP pulse is on the output.
        rot8   = 3;
        frame8 = pat8(3);
        repeat (3) tick();
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvLockFall, s, 0);
        push(0, EvSlip, s + 4, 3);
        tick();
        start8 = 1'b0;
        run_to(s + 4);
        reset_n = 1'b0;
        tick();
        chk("slip_rst_bitslip", int'(bs8), 0);
        chk("slip_rst_count", int'(cnt8), 0);
        chk("slip_rst_locked", int'(lk8), 0);
        chk("slip_rst_err", int'(err8), 0);
        reset_n = 1'b1;
        model8  = 1'b0;
        frame8  = '0;
        repeat (3) tick();

        // Alternating rotations never debounce: timeout after 1024 words.
        frame8 = pat8(1);
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvErrRise, s + 1024, 0);
        tick();
        start8 = 1'b0;
        while (cyc < s + 1030) begin
            frame8 = (frame8 == pat8(1)) ? pat8(2) : pat8(1);
            tick();
        end
        chk("timeout_err", int'(err8), 1);
        chk("timeout_locked", int'(lk8), 0);
        frame8 = pat8(0);
        repeat (10) tick();
        chk("fail_hold_err", int'(err8), 1);
        chk("fail_hold_locked", int'(lk8), 0);
        start8 = 1'b1;
        s = cyc + 1;
        push(0, EvErrFall, s, 0);
        push(0, EvLockRise, s + 4, 0);
        tick();
        start8 = 1'b0;
        run_to(s + 8);
        chk("restart_locked", int'(lk8), 1);

        // WIDTH=16, rotation 11: eleven pulses.
        model16 = 1'b1;
        rot16   = 11;
        frame16 = pat16(11);
        repeat (3) tick();
        start16 = 1'b1;
        s = cyc + 1;
        for (int j = 0; j < 11; j++) push(1, EvSlip, s + 4 + 5 * j, 11);
        push(1, EvLockRise, s + 63, 11);
        tick();
        start16 = 1'b0;
        run_to(s + 70);
        chk("w16_locked", int'(lk16), 1);
        chk("w16_count", int'(cnt16), 11);

        repeat (5) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d unmatched, want 0 (next cyc=%0d kind=%0d)",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].kind);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitslip_align.md
# bitslip_align

Parametrised frame-alignment controller for the ADC LVDS receive path, clocked in the deserialized (`clk_div`) domain. It sits between the frame-clock ISERDES and the data-lane ISERDES bank. It classifies the deserialized frame word and requires a stable rotation over several frames before acting. It then drives the BITSLIP pulses itself, verifies alignment, and monitors for loss of lock. It supersedes the count-only detector by generalising frame width and adding debounce, slip sequencing, verification, timeout and lock tracking.

## Interface
- `WIDTH`, 8: deserialization factor; even, 4..16.
- `MATCH_COUNT`, 4: consecutive identical classifications required; 1..255.
- `SETTLE_CYCLES`, 4: `clk_div` cycles waited after each bitslip pulse; ≥4.
- `LOSS_COUNT`, 8: consecutive non-aligned words in LOCKED that drop lock; 1..255.
- `TIMEOUT_FRAMES`, 1024: classified words allowed in SEARCH/VERIFY before failing.
- `clk_div`  in  1  sole clock, deserialized-word rate.
- `reset_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  qualifier; low freezes all state.
- `start`  in  1  one-cycle pulse; begin or restart alignment.
- `frame_in`  in  WIDTH  deserialized frame-clock word.
- `bitslip`  out  1  one-cycle pulse to all ISERDES BITSLIP inputs.
- `bitslip_count`  out  $clog2(WIDTH)  rotation detected, equal to the number of slips issued.
- `locked`  out  1  alignment achieved and held.
- `align_err`  out  1  sticky timeout flag.

## Operation
- Aligned pattern P0 = {WIDTH/2 zeros, WIDTH/2 ones}; for WIDTH=8 this is 8'b00001111.
- Pk = P0 rotated left by k. A word equal to some Pk is valid with rotation k. Any other word is invalid.
- Each bitslip pulse reduces the observed rotation by 1.
- `frame_in` passes through two registers (stage1, stage2) on each `ena` cycle. Classification uses stage2.
- States:
  - IDLE: initial state; waits for `start`.
  - SEARCH:
    - Valid word with the same k as the previous word increments the match counter. A different k sets the counter to 1. An invalid word sets it to 0.
    - Every word increments the timeout counter.
    - When the match counter reaches MATCH_COUNT, `bitslip_count` ← k. If k=0, go to LOCKED. Otherwise load remaining ← k and go to SLIP.
  - SLIP: `bitslip`=1 for one cycle, remaining decrements, go to SETTLE (counter ← SETTLE_CYCLES).
  - SETTLE: count down; words are ignored. At 0, go to SLIP if remaining>0, else go to VERIFY.
  - VERIFY: MATCH_COUNT consecutive P0 words lead to LOCKED. Any other word leads to SEARCH with the match counter cleared. The timeout counter keeps running.
  - LOCKED: `locked`=1. Consecutive non-P0 words are counted and any P0 word clears the count. Reaching LOSS_COUNT sets `locked`←0 and goes to SEARCH with the timeout counter cleared.
  - FAIL: entered when the timeout counter reaches TIMEOUT_FRAMES in SEARCH/VERIFY. Sets `align_err`=1 and holds until `start`.
- `start` in any state leads to SEARCH and clears the match, timeout, loss and remaining counters, `locked`, `align_err` and `bitslip_count`. `reset_n` low has higher priority.
- `ena`=0 freezes the pipeline, FSM and all counters, and forces `bitslip`=0. A SLIP cycle held during `ena`=0 pulses when `ena` returns.

## Timing
- Reset values: `bitslip`=0, `bitslip_count`=0, `locked`=0, `align_err`=0, state IDLE, stages 0.
- Latency from `frame_in` to classification is 2 `ena` cycles. All outputs are registered.
- With a stable word Pk present, lock takes about 2 + MATCH_COUNT + k·(1+SETTLE_CYCLES) + MATCH_COUNT cycles after `start`. For k=0 it is 2 + MATCH_COUNT.
- Bitslip pulses are exactly 1+SETTLE_CYCLES cycles apart and never back-to-back.
- `locked` falls in the cycle after the LOSS_COUNT-th bad word is classified.
- A `start` coinciding with a terminal-count event is honoured; `start` wins.

## Structure
- Package `bitslip_pkg`: state enum, default parameter constants, and the `P0` generation function.
- Sub-module `frame_pattern_classify`: combinational, parameter WIDTH. Maps a word to a valid flag and rotation k.

## Test plan
- WIDTH=8, constant 8'b00001111, `start` → zero bitslip pulses, `bitslip_count`=0, `locked`=1 six cycles after `start`.
- Constant 8'b11100001 with an ISERDES rotation model → five pulses 5 cycles apart, `bitslip_count`=5, `locked`=1 after verify.
- Words alternating 8'b00011110/8'b00111100 → no pulses, `align_err`=1 after 1024 words, state FAIL until `start`.
- LOCKED, then seven 8'hAA words followed by P0 → stays locked. Eight 8'hAA words → `locked`=0, re-search.
- `ena` low for 10 cycles mid-SETTLE → no pulse, counters frozen, sequence resumes. `reset_n` low during SLIP → all outputs 0 next edge.
- WIDTH=16, word P11 → eleven pulses, `bitslip_count`=11, `locked`=1.
